// File: rtl/lcd_char_queue.sv
// Character FIFO plus cursor sequencer that feeds an HD44780-style LCD controller.
// Buffers ALU bytes, inserts line-wrap DDRAM commands and maps form-feed onto clear-display.
module lcd_char_queue #(
    parameter int DEPTH = 16,
    parameter int COLS  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_write,
    input  logic [7:0]               i_data,
    output logic                     o_ready,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic [7:0]               o_lcd_data,
    output logic                     o_lcd_rs,
    output logic                     o_lcd_write,
    input  logic                     i_lcd_ready,
    input  logic                     i_lcd_initialized
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(COLS + 1);
    localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] COLS_C = CW'(COLS);
    localparam logic [7:0]    FF_CHAR   = 8'h0C;
    localparam logic [7:0]    CMD_CLEAR = 8'h01;
    localparam logic [7:0]    CMD_LINE0 = 8'h80;
    localparam logic [7:0]    CMD_LINE1 = 8'hC0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRAP_CMD,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_col;
    logic [CW-1:0] w_col_nxt;
    logic          r_line;
    logic          w_line_nxt;

    logic [7:0]    r_lcd_data;
    logic          r_lcd_rs;
    logic          r_lcd_write;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_strobe;
    logic [7:0]    w_out_data;
    logic          w_out_rs;
    logic [7:0]    w_head;

    assign w_full  = (r_count == FULL_C);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rptr];
    // A pop in the same cycle frees a slot, so a write at full is still taken then.
    assign w_push  = i_write & (~w_full | w_pop);

    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_ready     = ~w_full;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_lcd_data  = r_lcd_data;
    assign o_lcd_rs    = r_lcd_rs;
    assign o_lcd_write = r_lcd_write;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_write && !w_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_line      <= 1'b0;
            r_lcd_data  <= 8'h00;
            r_lcd_rs    <= 1'b0;
            r_lcd_write <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_line      <= w_line_nxt;
            r_lcd_write <= w_strobe;
            if (w_strobe) begin
                r_lcd_data <= w_out_data;
                r_lcd_rs   <= w_out_rs;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_line_nxt  = r_line;
        w_pop       = 1'b0;
        w_strobe    = 1'b0;
        w_out_data  = r_lcd_data;
        w_out_rs    = r_lcd_rs;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty && i_lcd_ready && i_lcd_initialized) begin
                    if (w_head == FF_CHAR)     w_state_nxt = S_ISSUE;
                    else if (r_col == COLS_C)  w_state_nxt = S_WRAP_CMD;
                    else                       w_state_nxt = S_ISSUE;
                end
            end
            S_WRAP_CMD: begin
                // Losing init between decision and strobe aborts without a write.
                if (!i_lcd_initialized) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_strobe    = 1'b1;
                    w_out_data  = r_line ? CMD_LINE0 : CMD_LINE1;
                    w_out_rs    = 1'b0;
                    w_col_nxt   = '0;
                    w_line_nxt  = ~r_line;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_ISSUE: begin
                if (!i_lcd_initialized) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_strobe    = 1'b1;
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT_ACK;
                    if (w_head == FF_CHAR) begin
                        w_out_data = CMD_CLEAR;
                        w_out_rs   = 1'b0;
                        w_col_nxt  = '0;
                        w_line_nxt = 1'b0;
                    end else begin
                        w_out_data = w_head;
                        w_out_rs   = 1'b1;
                        w_col_nxt  = r_col + CW'(1);
                    end
                end
            end
            S_WAIT_ACK: begin
                if (!i_lcd_ready) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_lcd_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
